// File: rtl/mem_resp_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_resp_stage_if
//  Brief    : EX->MEM payload, SRAM response, MEM->WB payload and ID bypass
//             signals of the MEM pipeline stage, bundled as one interface.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_resp_stage_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  // EX -> MEM
  logic              in_valid;
  logic              in_allowin;
  logic [PC_W-1:0]   in_pc;
  logic              in_rf_we;
  logic [4:0]        in_rf_waddr;
  logic [DATA_W-1:0] in_alu_result;
  logic [2:0]        in_ld_op;
  logic              in_mem_req;
  logic              flush;
  // SRAM response
  logic              data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;
  // MEM -> WB
  logic              out_valid;
  logic              out_allowin;
  logic [PC_W-1:0]   out_pc;
  logic              out_rf_we;
  logic [4:0]        out_rf_waddr;
  logic [DATA_W-1:0] out_rf_wdata;
  // MEM -> ID bypass
  logic              fwd_we;
  logic [4:0]        fwd_waddr;
  logic [DATA_W-1:0] fwd_wdata;
  logic              fwd_pending;

  // Environment side: EX, SRAM, WB and ID
  modport master (
    output in_valid, in_pc, in_rf_we, in_rf_waddr, in_alu_result, in_ld_op,
           in_mem_req, flush, data_sram_data_ok, data_sram_rdata, out_allowin,
    input  in_allowin, out_valid, out_pc, out_rf_we, out_rf_waddr, out_rf_wdata,
           fwd_we, fwd_waddr, fwd_wdata, fwd_pending
  );

  // MEM stage side
  modport slave (
    input  in_valid, in_pc, in_rf_we, in_rf_waddr, in_alu_result, in_ld_op,
           in_mem_req, flush, data_sram_data_ok, data_sram_rdata, out_allowin,
    output in_allowin, out_valid, out_pc, out_rf_we, out_rf_waddr, out_rf_wdata,
           fwd_we, fwd_waddr, fwd_wdata, fwd_pending
  );
endinterface
`default_nettype wire

// File: rtl/mem_resp_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_resp_stage
//  Brief    : MEM pipeline stage between EX and WB. Waits for load data,
//             aligns/extends it, holds it while WB stalls, bypasses to ID and
//             discards responses of requests cancelled by flush.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_resp_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 2
) (
  input  logic            clk,
  input  logic            resetn,
  mem_resp_stage_if.slave bus
);

  localparam int             c_off_w   = $clog2(DATA_W / 8);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_discard_cnt;
  logic [CNT_W-1:0]    w_discard_nxt;
  logic                w_cnt_zero;
  logic                w_capture;
  logic                w_load_done;
  logic                w_inc;
  logic                w_dec;

  logic [PC_W-1:0]     r_pc;
  logic                r_rf_we;
  logic [4:0]          r_rf_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [2:0]          r_ld_op;
  logic [c_off_w-1:0]  r_offset;

  logic [DATA_W-1:0]   w_shifted;
  logic [DATA_W-1:0]   w_ld_data;

  assign w_cnt_zero = (r_discard_cnt == '0);

  // State and discard counter; only these carry reset, payload does not
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_EMPTY;
      r_discard_cnt <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_discard_cnt <= w_discard_nxt;
    end
  end

  // Next state, capture/load-complete strobes and discard bookkeeping
  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_load_done   = 1'b0;
    w_discard_nxt = r_discard_cnt;
    // A response matches our own request only when nothing stale is pending
    w_dec = bus.data_sram_data_ok && !w_cnt_zero;
    w_inc = bus.flush && (r_state == S_WAIT) &&
            !(bus.data_sram_data_ok && w_cnt_zero);

    if (bus.flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (bus.in_valid) w_capture = 1'b1;
        end
        S_WAIT: begin
          if (bus.data_sram_data_ok && w_cnt_zero) begin
            w_load_done = 1'b1;
            w_state_nxt = S_FULL;
          end
        end
        S_FULL: begin
          if (bus.out_allowin) begin
            if (bus.in_valid) w_capture   = 1'b1;
            else              w_state_nxt = S_EMPTY;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
      if (w_capture) begin
        w_state_nxt = (bus.in_mem_req && (bus.in_ld_op != 3'd0)) ? S_WAIT : S_FULL;
      end
    end

    // Inc and dec together cancel out; increment saturates
    if (w_inc && !w_dec) begin
      if (r_discard_cnt != c_cnt_max) w_discard_nxt = r_discard_cnt + CNT_W'(1);
    end else if (w_dec && !w_inc) begin
      w_discard_nxt = r_discard_cnt - CNT_W'(1);
    end
  end

  // Payload registers: fresh capture from EX, or load data replacing the address
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_pc       <= bus.in_pc;
      r_rf_we    <= bus.in_rf_we;
      r_rf_waddr <= bus.in_rf_waddr;
      r_wdata    <= bus.in_alu_result;
      r_ld_op    <= bus.in_ld_op;
      r_offset   <= bus.in_alu_result[c_off_w-1:0];
    end else if (w_load_done) begin
      r_wdata    <= w_ld_data;
    end
  end

  assign w_shifted = bus.data_sram_rdata >> {r_offset, 3'b000};

  generate
    if (DATA_W == 64) begin : g_ext64
      // Extension for 64-bit datapath: b/h/w signed, bu/hu/wu unsigned, d raw
      always_comb begin
        w_ld_data = w_shifted;
        case (r_ld_op)
          3'd1: w_ld_data = {{(DATA_W-8){w_shifted[7]}},   w_shifted[7:0]};
          3'd2: w_ld_data = {{(DATA_W-8){1'b0}},           w_shifted[7:0]};
          3'd3: w_ld_data = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
          3'd4: w_ld_data = {{(DATA_W-16){1'b0}},          w_shifted[15:0]};
          3'd5: w_ld_data = {{(DATA_W-32){w_shifted[31]}}, w_shifted[31:0]};
          3'd6: w_ld_data = {{(DATA_W-32){1'b0}},          w_shifted[31:0]};
          default: w_ld_data = w_shifted;
        endcase
      end
    end else begin : g_ext32
      // Extension for 32-bit datapath: wu and d collapse to a plain word
      always_comb begin
        w_ld_data = w_shifted;
        case (r_ld_op)
          3'd1: w_ld_data = {{(DATA_W-8){w_shifted[7]}},   w_shifted[7:0]};
          3'd2: w_ld_data = {{(DATA_W-8){1'b0}},           w_shifted[7:0]};
          3'd3: w_ld_data = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
          3'd4: w_ld_data = {{(DATA_W-16){1'b0}},          w_shifted[15:0]};
          default: w_ld_data = w_shifted;
        endcase
      end
    end
  endgenerate

  assign bus.in_allowin   = (r_state == S_EMPTY) || ((r_state == S_FULL) && bus.out_allowin);
  assign bus.out_valid    = (r_state == S_FULL);
  assign bus.out_pc       = r_pc;
  assign bus.out_rf_we    = r_rf_we;
  assign bus.out_rf_waddr = r_rf_waddr;
  assign bus.out_rf_wdata = r_wdata;
  assign bus.fwd_we       = (r_state != S_EMPTY) && r_rf_we;
  assign bus.fwd_waddr    = r_rf_waddr;
  assign bus.fwd_wdata    = r_wdata;
  assign bus.fwd_pending  = (r_state == S_WAIT);

endmodule
`default_nettype wire
